c2v_symconv_pipe: RTL and testbench
===================================

Name: c2v_symconv_pipe

Overview:
- Multi-lane, pipelined C2V sign-conversion stage for the IB-LUT partial VNU.
- Holds the V2C (or channel) sign of every lane per row-group address in a small flop array, written during the V2C phase.
- When a raw C2V word arrives with its row-group address, each lane's output sign is the stored V2C sign XOR the C2V sign bit; magnitude bits pass through unchanged.
- Valid/ready handshake on both sides, so it sits between the C2V message memory read port and the VNU accumulator and absorbs backpressure.

Parameters:
- MSG_WIDTH, 4, bits per C2V message: sign at MSB, magnitude in the lower MSG_WIDTH-1 bits.
- LANE_NUM, 8, number of parallel messages (columns) per word.
- SIGN_DEPTH, 16, number of row-group sign entries.
- ADDR_WIDTH, $clog2(SIGN_DEPTH), sign-array address width.

Ports:
- sys_clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sign_wr_en_i  in  1  write LANE_NUM V2C signs this cycle
- sign_wr_addr_i  in  ADDR_WIDTH  sign-array write address
- sign_wr_data_i  in  LANE_NUM  one V2C sign per lane, bit i = lane i
- c2v_valid_i  in  1  raw C2V word valid
- c2v_ready_o  out  1  stage can accept a C2V word
- c2v_addr_i  in  ADDR_WIDTH  row-group address of the C2V word
- c2v_msg_i  in  LANE_NUM*MSG_WIDTH  raw C2V messages, lane i at [i*MSG_WIDTH +: MSG_WIDTH]
- conv_valid_o  out  1  converted word valid
- conv_ready_i  in  1  downstream accepts
- conv_msg_o  out  LANE_NUM*MSG_WIDTH  sign-converted messages, same lane packing as c2v_msg_i
- conv_addr_o  out  ADDR_WIDTH  address carried alongside the converted word

Behaviour:
- Reset (rstn low, asynchronous):
  - sign array cleared to all 0.
  - s1_valid and s2_valid cleared; conv_valid_o = 0; conv_msg_o = 0; conv_addr_o = 0.
  - c2v_ready_o = 1 one cycle after reset release; it is held 0 while rstn is low.
  - A reset mid-transfer drops every in-flight word; nothing is replayed.
- Sign array write: on a rising edge with sign_wr_en_i = 1, entry[sign_wr_addr_i] <= sign_wr_data_i. Writes are not throttled by any handshake.
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Once asserted, conv_valid_o is held, with conv_msg_o and conv_addr_o stable, until conv_ready_i = 1.
- Stage 1 (S1), input register:
  - Captures c2v_msg_i, c2v_addr_i and the per-lane sign vector read from entry[c2v_addr_i].
  - Write/read collision: if sign_wr_en_i is high with sign_wr_addr_i == c2v_addr_i in the same cycle, S1 captures sign_wr_data_i (write-first bypass).
- Stage 2 (S2), output register: conv_msg_o lane i = {sign_i ^ msg_i[MSG_WIDTH-1], msg_i[MSG_WIDTH-2:0]}.
- Stage advance:
  - s2_load = s1_valid & (!s2_valid | conv_ready_i).
  - c2v_ready_o = !s1_valid | s2_load, registered-free, so no combinational path from c2v_valid_i.
  - Full throughput is 1 word per cycle; with a full pipe and conv_ready_i low, c2v_ready_o = 0.
- Latency: 2 cycles from an accepted input to conv_valid_o when downstream is ready.
- Simultaneous events:
  - S1 loading and S2 draining in the same cycle is legal and causes no bubble.
  - Sign writes to a word already in S1 do not affect that word; its sign was sampled at S1 capture.
- Out-of-range address (SIGN_DEPTH not a power of 2): reads return 0, writes are ignored.

Optional Feature:
- Macro: C2V_SYMCONV_ZERO_CLR_EN.
- Defined: for any lane whose magnitude bits are all 0, the output sign is forced to 0, so no negative-zero code is emitted. A 16-bit saturating counter, exposed as output port zero_clr_cnt_o [15:0], increments once per transferred output word that contains at least one such lane. The counter resets to 0 on rstn and holds at 0xFFFF.
- Not defined: pure XOR conversion, including zero magnitudes; the zero_clr_cnt_o port does not exist.

Test Plan:
- Basic conversion: write entry 3 = 8'b0000_0101, then send C2V addr 3 with lane0 = 4'b0011 and lane2 = 4'b1010, conv_ready_i = 1 -> 2 cycles later conv_valid_o = 1, lane0 = 4'b1011, lane2 = 4'b0010, conv_addr_o = 3.
- Collision bypass: same cycle write entry 5 = 8'hFF and send C2V addr 5 with all lanes 4'b0001 -> all lanes output 4'b1001, not the stale entry value 0.
- Backpressure: stream 6 words back-to-back with conv_ready_i low from cycle 2 to cycle 5 -> c2v_ready_o drops once S1 and S2 are full; outputs hold stable; all 6 words arrive in order with no loss or duplication.
- Throughput: 32 consecutive words with conv_ready_i = 1 -> 32 outputs on 32 consecutive cycles after a 2-cycle latency.
- Reset mid-operation: assert rstn low while S1 and S2 are valid -> conv_valid_o = 0 immediately (asynchronously); after release, sign entries read 0 and the first new word emerges with unflipped signs.
- C2V_SYMCONV_ZERO_CLR_EN: entry 0 = 8'h01, lane0 = 4'b0000 -> lane0 out = 4'b0000 and zero_clr_cnt_o increments by 1. Without the macro, lane0 out = 4'b1000.

Source files
------------

// File: rtl/c2v_symconv_pipe.sv
// Two-stage valid/ready C2V sign-conversion pipe: per-row-group V2C sign store, sign XOR, magnitude pass-through.
// Optional C2V_SYMCONV_ZERO_CLR_EN: suppress negative zero and count affected output words on zero_clr_cnt_o.
module c2v_symconv_pipe #(
  parameter int unsigned MSG_WIDTH  = 4,
  parameter int unsigned LANE_NUM   = 8,
  parameter int unsigned SIGN_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(SIGN_DEPTH)
) (
  input  logic                          sys_clk,
  input  logic                          rstn,
  input  logic                          sign_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]         sign_wr_addr_i,
  input  logic [LANE_NUM-1:0]           sign_wr_data_i,
  input  logic                          c2v_valid_i,
  output logic                          c2v_ready_o,
  input  logic [ADDR_WIDTH-1:0]         c2v_addr_i,
  input  logic [LANE_NUM*MSG_WIDTH-1:0] c2v_msg_i,
  output logic                          conv_valid_o,
  input  logic                          conv_ready_i,
  output logic [LANE_NUM*MSG_WIDTH-1:0] conv_msg_o,
  output logic [ADDR_WIDTH-1:0]         conv_addr_o
`ifdef C2V_SYMCONV_ZERO_CLR_EN
  ,
  output logic [15:0]                   zero_clr_cnt_o
`endif
);

  localparam int unsigned DW = LANE_NUM * MSG_WIDTH;

  logic [LANE_NUM-1:0]   sign_q [SIGN_DEPTH];
  logic [LANE_NUM-1:0]   sign_d [SIGN_DEPTH];
  logic [LANE_NUM-1:0]   rd_sign;

  logic                  rdy_en_q;
  logic                  s1_load;
  logic                  s2_load;

  logic                  s1_valid_q, s1_valid_d;
  logic [DW-1:0]         s1_msg_q,   s1_msg_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
  logic [LANE_NUM-1:0]   s1_sign_q,  s1_sign_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DW-1:0]         s2_msg_q,   s2_msg_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q,  s2_addr_d;

  logic [DW-1:0]         conv_word;
  logic                  sgn;

`ifdef C2V_SYMCONV_ZERO_CLR_EN
  logic                  zero_any;
  logic                  s2_zero_q, s2_zero_d;
  logic [15:0]           cnt_q, cnt_d;
`endif

  // Entries outside SIGN_DEPTH never match an address, so such writes drop and reads return 0.
  always_comb begin
    for (int unsigned e = 0; e < SIGN_DEPTH; e++) begin
      sign_d[e] = sign_q[e];
      if (sign_wr_en_i && (sign_wr_addr_i == ADDR_WIDTH'(e))) begin
        sign_d[e] = sign_wr_data_i;
      end
    end
  end

  // Reading the next-state array gives the write-first bypass on a same-cycle collision.
  always_comb begin
    rd_sign = '0;
    for (int unsigned e = 0; e < SIGN_DEPTH; e++) begin
      if (c2v_addr_i == ADDR_WIDTH'(e)) begin
        rd_sign = sign_d[e];
      end
    end
  end

  always_comb begin
    s2_load     = s1_valid_q & (~s2_valid_q | conv_ready_i);
    c2v_ready_o = rdy_en_q & (~s1_valid_q | s2_load);
    s1_load     = c2v_valid_i & c2v_ready_o;
  end

  always_comb begin
    conv_word = s1_msg_q;
    sgn       = 1'b0;
`ifdef C2V_SYMCONV_ZERO_CLR_EN
    zero_any  = 1'b0;
`endif
    for (int unsigned l = 0; l < LANE_NUM; l++) begin
      sgn = s1_sign_q[l] ^ s1_msg_q[l*MSG_WIDTH + MSG_WIDTH - 1];
`ifdef C2V_SYMCONV_ZERO_CLR_EN
      if (s1_msg_q[l*MSG_WIDTH +: MSG_WIDTH-1] == '0) begin
        sgn      = 1'b0;
        zero_any = 1'b1;
      end
`endif
      conv_word[l*MSG_WIDTH + MSG_WIDTH - 1] = sgn;
    end
  end

  always_comb begin
    s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    s1_msg_d   = s1_msg_q;
    s1_addr_d  = s1_addr_q;
    s1_sign_d  = s1_sign_q;
    if (s1_load) begin
      s1_msg_d  = c2v_msg_i;
      s1_addr_d = c2v_addr_i;
      s1_sign_d = rd_sign;
    end

    s2_valid_d = s2_load | (s2_valid_q & ~conv_ready_i);
    s2_msg_d   = s2_msg_q;
    s2_addr_d  = s2_addr_q;
    if (s2_load) begin
      s2_msg_d  = conv_word;
      s2_addr_d = s1_addr_q;
    end
  end

`ifdef C2V_SYMCONV_ZERO_CLR_EN
  always_comb begin
    s2_zero_d = s2_load ? zero_any : s2_zero_q;
    cnt_d     = cnt_q;
    if (s2_valid_q && conv_ready_i && s2_zero_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s2_zero_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s2_zero_q <= s2_zero_d;
      cnt_q     <= cnt_d;
    end
  end

  assign zero_clr_cnt_o = cnt_q;
`endif

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned e = 0; e < SIGN_DEPTH; e++) begin
        sign_q[e] <= '0;
      end
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_msg_q   <= '0;
      s1_addr_q  <= '0;
      s1_sign_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_msg_q   <= '0;
      s2_addr_q  <= '0;
    end else begin
      for (int unsigned e = 0; e < SIGN_DEPTH; e++) begin
        sign_q[e] <= sign_d[e];
      end
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_msg_q   <= s1_msg_d;
      s1_addr_q  <= s1_addr_d;
      s1_sign_q  <= s1_sign_d;
      s2_valid_q <= s2_valid_d;
      s2_msg_q   <= s2_msg_d;
      s2_addr_q  <= s2_addr_d;
    end
  end

  assign conv_valid_o = s2_valid_q;
  assign conv_msg_o   = s2_msg_q;
  assign conv_addr_o  = s2_addr_q;

endmodule

// File: tb/tb_c2v_symconv_pipe.sv
// Directed bench for c2v_symconv_pipe: reset, conversion, collision bypass, backpressure, throughput, mid-run reset.
module tb_c2v_symconv_pipe;

  localparam int unsigned MW = 4;
  localparam int unsigned LN = 8;
  localparam int unsigned AW = 4;

  logic          sys_clk = 1'b0;
  logic          rstn;
  logic          sign_wr_en_i;
  logic [AW-1:0] sign_wr_addr_i;
  logic [LN-1:0] sign_wr_data_i;
  logic          c2v_valid_i;
  logic          c2v_ready_o;
  logic [AW-1:0] c2v_addr_i;
  logic [31:0]   c2v_msg_i;
  logic          conv_valid_o;
  logic          conv_ready_i;
  logic [31:0]   conv_msg_o;
  logic [AW-1:0] conv_addr_o;
`ifdef C2V_SYMCONV_ZERO_CLR_EN
  logic [15:0]   zero_clr_cnt_o;
`endif

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 sys_clk = ~sys_clk;

  c2v_symconv_pipe #(
    .MSG_WIDTH (MW),
    .LANE_NUM  (LN),
    .SIGN_DEPTH(16)
  ) dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .sign_wr_en_i  (sign_wr_en_i),
    .sign_wr_addr_i(sign_wr_addr_i),
    .sign_wr_data_i(sign_wr_data_i),
    .c2v_valid_i   (c2v_valid_i),
    .c2v_ready_o   (c2v_ready_o),
    .c2v_addr_i    (c2v_addr_i),
    .c2v_msg_i     (c2v_msg_i),
    .conv_valid_o  (conv_valid_o),
    .conv_ready_i  (conv_ready_i),
    .conv_msg_o    (conv_msg_o),
    .conv_addr_o   (conv_addr_o)
`ifdef C2V_SYMCONV_ZERO_CLR_EN
    ,
    .zero_clr_cnt_o(zero_clr_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr_sign(input logic [AW-1:0] a, input logic [LN-1:0] d);
    sign_wr_en_i   = 1'b1;
    sign_wr_addr_i = a;
    sign_wr_data_i = d;
    tick();
    sign_wr_en_i   = 1'b0;
  endtask

  task automatic send1(input string tag, input logic [AW-1:0] a, input logic [31:0] m,
                       input logic [31:0] exp);
    c2v_valid_i = 1'b1;
    c2v_addr_i  = a;
    c2v_msg_i   = m;
    tick();
    c2v_valid_i = 1'b0;
    tick();
    chk({tag, "_vld"}, {31'd0, conv_valid_o}, 32'd1);
    chk({tag, "_msg"}, conv_msg_o, exp);
    chk({tag, "_adr"}, {28'd0, conv_addr_o}, {28'd0, a});
    tick();
  endtask

  function automatic logic [31:0] tp_word(input int unsigned i);
    logic [3:0] nb;
    nb = 4'((i % 7) + 1);
    if ((i % 2) == 1) nb[3] = 1'b1;
    return {8{nb}};
  endfunction

  logic [31:0] bp_in  [6];
  logic [31:0] bp_exp [6];
  logic [31:0] held_msg;
  logic        held;
  int unsigned idx, oidx;
`ifdef C2V_SYMCONV_ZERO_CLR_EN
  logic [15:0] cnt0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bp_in[0] = 32'h1234_5671; bp_exp[0] = 32'h9ABC_5671;
    bp_in[1] = 32'h7654_3217; bp_exp[1] = 32'hFEDC_3217;
    bp_in[2] = 32'h9ABC_DEF1; bp_exp[2] = 32'h1234_DEF1;
    bp_in[3] = 32'h1111_2222; bp_exp[3] = 32'h9999_2222;
    bp_in[4] = 32'hFEDC_BA97; bp_exp[4] = 32'h7654_BA97;
    bp_in[5] = 32'h3579_1357; bp_exp[5] = 32'hBDF1_1357;

    rstn           = 1'b0;
    sign_wr_en_i   = 1'b0;
    sign_wr_addr_i = '0;
    sign_wr_data_i = '0;
    c2v_valid_i    = 1'b0;
    c2v_addr_i     = '0;
    c2v_msg_i      = '0;
    conv_ready_i   = 1'b1;

    // reset state
    #2;
    chk("rst_vld", {31'd0, conv_valid_o}, 32'd0);
    chk("rst_msg", conv_msg_o, 32'd0);
    chk("rst_adr", {28'd0, conv_addr_o}, 32'd0);
    tick();
    tick();
    chk("rst_rdy", {31'd0, c2v_ready_o}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rdy_pre", {31'd0, c2v_ready_o}, 32'd0);
    tick();
    chk("rdy_post", {31'd0, c2v_ready_o}, 32'd1);

    // basic conversion with latency
    wr_sign(4'd3, 8'b0000_0101);
    c2v_valid_i = 1'b1;
    c2v_addr_i  = 4'd3;
    c2v_msg_i   = 32'h0000_0A03;
    tick();
    c2v_valid_i = 1'b0;
    chk("bas_lat1", {31'd0, conv_valid_o}, 32'd0);
    tick();
    chk("bas_vld", {31'd0, conv_valid_o}, 32'd1);
    chk("bas_msg", conv_msg_o, 32'h0000_020B);
    chk("bas_adr", {28'd0, conv_addr_o}, 32'd3);
    tick();
    chk("bas_drain", {31'd0, conv_valid_o}, 32'd0);

    // collision bypass, then a write while the word sits in S1
    sign_wr_en_i   = 1'b1;
    sign_wr_addr_i = 4'd5;
    sign_wr_data_i = 8'hFF;
    c2v_valid_i    = 1'b1;
    c2v_addr_i     = 4'd5;
    c2v_msg_i      = 32'h1111_1111;
    tick();
    c2v_valid_i    = 1'b0;
    sign_wr_data_i = 8'h00;
    tick();
    sign_wr_en_i   = 1'b0;
    chk("col_vld", {31'd0, conv_valid_o}, 32'd1);
    chk("col_msg", conv_msg_o, 32'h9999_9999);
    tick();
    send1("col_after", 4'd5, 32'h1111_1111, 32'h1111_1111);

    // backpressure stream of 6 words
    wr_sign(4'd7, 8'hF0);
    idx  = 0;
    oidx = 0;
    held = 1'b0;
    held_msg = '0;
    for (int c = 0; c < 40 && oidx < 6; c++) begin
      c2v_valid_i  = (idx < 6);
      c2v_addr_i   = 4'd7;
      c2v_msg_i    = (idx < 6) ? bp_in[idx] : 32'd0;
      conv_ready_i = !(c >= 2 && c <= 5);
      #1;
      if (c == 3) chk("bp_rdy_low", {31'd0, c2v_ready_o}, 32'd0);
      if (held) begin
        chk("bp_hold_vld", {31'd0, conv_valid_o}, 32'd1);
        chk("bp_hold_msg", conv_msg_o, held_msg);
      end
      held     = conv_valid_o && !conv_ready_i;
      held_msg = conv_msg_o;
      if (conv_valid_o && conv_ready_i) begin
        chk("bp_msg", conv_msg_o, bp_exp[oidx]);
        chk("bp_adr", {28'd0, conv_addr_o}, 32'd7);
        oidx++;
      end
      if (c2v_valid_i && c2v_ready_o) idx++;
      tick();
    end
    c2v_valid_i  = 1'b0;
    conv_ready_i = 1'b1;
    chk("bp_count", oidx, 32'd6);
    chk("bp_dup", {31'd0, conv_valid_o}, 32'd0);

    // throughput: 32 words back-to-back to entry 3 (lanes 0 and 2 flip)
    idx  = 0;
    oidx = 0;
    for (int c = 0; c < 60 && oidx < 32; c++) begin
      c2v_valid_i = (idx < 32);
      c2v_addr_i  = 4'd3;
      c2v_msg_i   = tp_word(idx);
      #1;
      if (idx < 32) chk("tp_rdy", {31'd0, c2v_ready_o}, 32'd1);
      if (conv_valid_o) begin
        chk("tp_msg", conv_msg_o, tp_word(oidx) ^ 32'h0000_0808);
        chk("tp_lat", c - oidx, 32'd2);
        oidx++;
      end
      if (c2v_valid_i && c2v_ready_o) idx++;
      tick();
    end
    c2v_valid_i = 1'b0;
    chk("tp_count", oidx, 32'd32);

    // asynchronous reset with both stages full
    conv_ready_i = 1'b0;
    c2v_valid_i  = 1'b1;
    c2v_addr_i   = 4'd3;
    c2v_msg_i    = 32'h1111_1111;
    tick();
    tick();
    c2v_valid_i = 1'b0;
    chk("mr_full", {31'd0, conv_valid_o}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_vld", {31'd0, conv_valid_o}, 32'd0);
    chk("mr_msg", conv_msg_o, 32'd0);
    chk("mr_rdy", {31'd0, c2v_ready_o}, 32'd0);
    tick();
    rstn         = 1'b1;
    conv_ready_i = 1'b1;
    tick();
    chk("mr_rdy_back", {31'd0, c2v_ready_o}, 32'd1);
    chk("mr_noreplay", {31'd0, conv_valid_o}, 32'd0);
    send1("mr_e3", 4'd3, 32'h0000_0A03, 32'h0000_0A03);
    send1("mr_e7", 4'd7, 32'h1111_1111, 32'h1111_1111);

    // zero magnitude handling
    wr_sign(4'd0, 8'h01);
`ifdef C2V_SYMCONV_ZERO_CLR_EN
    cnt0 = zero_clr_cnt_o;
    send1("zero", 4'd0, 32'h0000_0000, 32'h0000_0000);
    chk("zero_cnt", {16'd0, zero_clr_cnt_o}, {16'd0, cnt0 + 16'd1});
`else
    send1("zero", 4'd0, 32'h0000_0000, 32'h0000_0008);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
